// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between the datapath memory port and the responder.
interface mem_responder_if;
    logic        req;
    logic        wr;
    logic [31:0] address;
    logic [31:0] data_in;
    logic        ready;
    logic        ack;
    logic        err;
    logic [31:0] data_out;
    modport master (output req, wr, address, data_in, input ready, ack, err, data_out);
    modport slave  (input req, wr, address, data_in, output ready, ack, err, data_out);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word memory answering one request at a time with a one-cycle ack after WAIT_STATES wait cycles.
module mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    mem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic        r_wr, r_err;
    logic [31:0] r_addr, r_din, r_dout;
    logic [31:0] r_mem [DEPTH];
    logic        w_accept, w_to_resp, w_wr, w_bad;
    logic [31:0] w_addr, w_din;
    logic [AW-1:0] w_idx;
    always_comb begin
        w_accept = r_state == S_IDLE && bus.req;
        w_next = r_state;
        if (w_accept) w_next = WAIT_STATES == 0 ? S_RESP : S_WAIT;
        else if (r_state == S_WAIT && r_cnt <= 4'd1) w_next = S_RESP;
        else if (r_state == S_RESP) w_next = S_IDLE;
        w_to_resp = w_next == S_RESP && r_state != S_RESP;
        // with zero wait states the access happens on the accept edge itself
        w_addr = r_state == S_IDLE ? bus.address : r_addr;
        w_din  = r_state == S_IDLE ? bus.data_in : r_din;
        w_wr   = r_state == S_IDLE ? bus.wr : r_wr;
        w_bad  = w_addr[1:0] != 2'b00 || w_addr[31:2] >= 30'(DEPTH);
        w_idx  = w_addr[AW+1:2];
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else r_state <= w_next;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_wr   <= 1'b0;
            r_err  <= 1'b0;
            r_addr <= '0;
            r_din  <= '0;
            r_dout <= '0;
        end else begin
            r_err <= w_to_resp && w_bad;
            if (w_accept) begin
                r_cnt  <= 4'(WAIT_STATES);
                r_addr <= bus.address;
                r_din  <= bus.data_in;
                r_wr   <= bus.wr;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            if (w_to_resp && !w_wr) r_dout <= w_bad ? '0 : r_mem[w_idx];
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_to_resp && w_wr && !w_bad) r_mem[w_idx] <= w_din;
    end
    assign bus.ready    = r_state == S_IDLE;
    assign bus.ack      = r_state == S_RESP;
    assign bus.err      = r_err;
    assign bus.data_out = r_dout;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder with a transaction-level reference model for the WAIT_STATES=2 instance.
module tb_mem_responder;
    localparam int MW = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    mem_responder_if b2 ();
    mem_responder_if b0 ();
    mem_responder #(.DEPTH(256), .WAIT_STATES(MW)) dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(b2));
    mem_responder #(.DEPTH(256), .WAIT_STATES(0))  dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(b0));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an access completes MW edges after the accept edge, then one idle-return edge.
    logic        m_ready = 1'b1, m_ack = 1'b0, m_err = 1'b0, m_pend = 1'b0, m_wr = 1'b0;
    logic [31:0] m_dout = '0, m_a = '0, m_d = '0;
    logic [31:0] m_mem [256];
    int          n = 0, m_acc = 0;
    function automatic bit bad(input logic [31:0] a);
        return a[1:0] != 2'b00 || (a >> 2) >= 32'd256;
    endfunction
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 1'b1; m_ack <= 1'b0; m_err <= 1'b0; m_dout <= '0; m_pend <= 1'b0;
        end else begin
            n <= n + 1;
            if (m_ready && b2.req) begin
                m_ready <= 1'b0; m_pend <= 1'b1; m_acc <= n;
                m_wr <= b2.wr; m_a <= b2.address; m_d <= b2.data_in;
            end
            if (m_ack) begin
                m_ack <= 1'b0; m_err <= 1'b0; m_ready <= 1'b1;
            end
            if (m_pend && n == m_acc + MW) begin
                m_pend <= 1'b0; m_ack <= 1'b1; m_err <= bad(m_a);
                if (m_wr && !bad(m_a)) m_mem[m_a[9:2]] <= m_d;
                if (!m_wr) m_dout <= bad(m_a) ? 32'd0 : m_mem[m_a[9:2]];
            end
        end
    end
    always @(negedge clk) begin
        chk("model_ready", 32'(b2.ready), 32'(m_ready));
        chk("model_ack", 32'(b2.ack), 32'(m_ack));
        chk("model_err", 32'(b2.err), 32'(m_err));
        chk("model_dout", b2.data_out, m_dout);
    end

    function automatic logic sig_ack(input bit z);
        return z ? b0.ack : b2.ack;
    endfunction
    task automatic wait_ack(input bit z, output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            if (sig_ack(z)) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        if (lat == 0) chk("ack_timeout", 32'(lat), 32'd1);
    endtask
    task automatic xact(input bit z, input bit w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic e, output logic [31:0] q);
        @(negedge clk);
        chk("ready_before_req", 32'(z ? b0.ready : b2.ready), 32'd1);
        if (z) begin b0.req = 1'b1; b0.wr = w; b0.address = a; b0.data_in = d; end
        else   begin b2.req = 1'b1; b2.wr = w; b2.address = a; b2.data_in = d; end
        @(posedge clk);
        @(negedge clk);
        if (z) begin b0.req = 1'b0; b0.wr = ~w; b0.address = '1; b0.data_in = ~d; end
        else   begin b2.req = 1'b0; b2.wr = ~w; b2.address = '1; b2.data_in = ~d; end
        wait_ack(z, lat);
        e = z ? b0.err : b2.err;
        q = z ? b0.data_out : b2.data_out;
    endtask

    int lat, e5;
    logic er, r;
    logic [31:0] q;
    initial begin
        {b2.req, b2.wr, b2.address, b2.data_in} = '0;
        {b0.req, b0.wr, b0.address, b0.data_in} = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        xact(0, 1, 32'h10, 32'hDEADBEEF, lat, er, q);
        chk("wr10_latency", 32'(lat), 32'd3);
        chk("wr10_err", 32'(er), 32'd0);
        xact(0, 0, 32'h10, 32'h0, lat, er, q);
        chk("rd10_latency", 32'(lat), 32'd3);
        chk("rd10_data", q, 32'hDEADBEEF);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(b2.ready), 32'd1);
        chk("rst_ack", 32'(b2.ack), 32'd0);
        chk("rst_err", 32'(b2.err), 32'd0);
        chk("rst_dout", b2.data_out, 32'd0);
        #1 rst_n = 1'b1;
        xact(0, 1, 32'h13, 32'h12345678, lat, er, q);
        chk("wr13_err", 32'(er), 32'd1);
        xact(0, 0, 32'h10, 32'h0, lat, er, q);
        chk("rd10_after_bad_wr", q, 32'hDEADBEEF);
        chk("rd10_after_bad_wr_err", 32'(er), 32'd0);
        xact(0, 0, 32'h400, 32'h0, lat, er, q);
        chk("rd400_err", 32'(er), 32'd1);
        chk("rd400_data", q, 32'd0);
        xact(0, 1, 32'h3FC, 32'h3FC0FFEE, lat, er, q);
        xact(0, 0, 32'h3FC, 32'h0, lat, er, q);
        chk("rd3fc_err", 32'(er), 32'd0);
        chk("rd3fc_data", q, 32'h3FC0FFEE);
        @(negedge clk);
        b2.req = 1'b1; b2.wr = 1'b1; b2.address = 32'h20; b2.data_in = 32'hA;
        @(posedge clk);
        @(negedge clk);
        b2.data_in = 32'hB; b2.wr = 1'b0;
        e5 = 0;
        for (int i = 0; i < 20; i++) begin
            r = b2.ready;
            @(posedge clk);
            e5++;
            if (r) break;
            @(negedge clk);
        end
        chk("held_req_reaccept_edges", 32'(e5), 32'd4);
        @(negedge clk);
        b2.req = 1'b0;
        wait_ack(0, lat);
        chk("held_req_rd_latency", 32'(lat), 32'd3);
        chk("held_req_rd_data", b2.data_out, 32'hA);
        xact(0, 1, 32'h24, 32'h55, lat, er, q);
        chk("wr24_err", 32'(er), 32'd0);
        @(negedge clk);
        b2.req = 1'b1; b2.wr = 1'b1; b2.address = 32'h24; b2.data_in = 32'h99;
        @(posedge clk);
        @(negedge clk);
        b2.req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midwait_rst_ready", 32'(b2.ready), 32'd1);
        chk("midwait_rst_ack", 32'(b2.ack), 32'd0);
        #1 rst_n = 1'b1;
        xact(0, 0, 32'h24, 32'h0, lat, er, q);
        chk("rd24_after_abort", q, 32'h55);
        xact(1, 1, 32'h8, 32'h77, lat, er, q);
        chk("w0_wr_latency", 32'(lat), 32'd1);
        chk("w0_wr_err", 32'(er), 32'd0);
        xact(1, 0, 32'h8, 32'h0, lat, er, q);
        chk("w0_rd_latency", 32'(lat), 32'd1);
        chk("w0_rd_data", q, 32'h77);
        xact(1, 0, 32'h9, 32'h0, lat, er, q);
        chk("w0_misaligned_err", 32'(er), 32'd1);
        chk("w0_misaligned_data", q, 32'd0);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
